// File: rtl/vcc_pok_seq_pkg.sv
// Shared types and helpers for the VCC power-good sequencer.
package vcc_pok_seq_pkg;

   localparam int StateW = 3;

   typedef enum logic [StateW-1:0] {
      ST_OFF      = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_RAMP     = 3'd2,
      ST_ON       = 3'd3,
      ST_DOWN     = 3'd4
   } state_e;

   // Clears the highest set bit; on a thermometer code this peels off the top domain.
   function automatic logic [7:0] therm_clr_top(logic [7:0] v);
      logic [7:0] r;
      logic       done;
      r    = v;
      done = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (!done && v[i]) begin
            r[i] = 1'b0;
            done = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Library two-flop synchronizer primitive with configurable width and reset value.
module prim_flop_2sync #(
   parameter int               Width      = 16,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta <= ResetValue;
         q_o  <= ResetValue;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/vcc_pok_seq.sv
// Power-good sequencer: synchronize/debounce vcc_pok_i, ramp domains up in order, tear down in reverse.
// Optional glitch counter enabled by defining VCC_POK_SEQ_GLITCH_CNT_EN.
module vcc_pok_seq
   import vcc_pok_seq_pkg::*;
#(
   parameter int SyncStages     = 2,
   parameter int DebounceCycles = 16,
   parameter int StepCycles     = 8,
   parameter int NumDomains     = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  vcc_pok_i,
   output logic                  pok_sync_o,
   output logic [NumDomains-1:0] dom_en_o,
   output logic                  pwr_good_o,
   output logic                  brownout_o,
   output logic [2:0]            state_o
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
   ,
   input  logic                  glitch_clr_i,
   output logic [7:0]            glitch_cnt_o
`endif
);

   localparam int DW = $clog2(DebounceCycles + 1);
   localparam int SW = $clog2(StepCycles + 1);
   localparam int IW = $clog2(NumDomains + 1);
   localparam logic [DW-1:0] DbncLast = DW'(DebounceCycles - 1);
   localparam logic [SW-1:0] StepLast = SW'(StepCycles - 1);
   localparam logic [IW-1:0] IdxLast  = IW'(NumDomains - 1);

   logic sync2;

   prim_flop_2sync #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (vcc_pok_i),
      .q_o    (sync2)
   );

   // Extra stages beyond the primitive's two when a deeper synchronizer is requested.
   if (SyncStages > 2) begin : g_ext
      logic [SyncStages-3:0] ext;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ext <= '0;
         end else begin
            ext[0] <= sync2;
            for (int i = 1; i < SyncStages - 2; i++) ext[i] <= ext[i-1];
         end
      end
      assign pok_sync_o = ext[SyncStages-3];
   end else begin : g_noext
      assign pok_sync_o = sync2;
   end

   state_e                state, state_n;
   logic [DW-1:0]         dbnc_cnt, dbnc_n;
   logic [SW-1:0]         step_cnt, step_n;
   logic [IW-1:0]         idx, idx_n;
   logic [NumDomains-1:0] dom_en, dom_en_n;
   logic                  pwr_good, pg_n, brownout, bo_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_OFF;
         dbnc_cnt <= '0;
         step_cnt <= '0;
         idx      <= '0;
         dom_en   <= '0;
         pwr_good <= 1'b0;
         brownout <= 1'b0;
      end else begin
         state    <= state_n;
         dbnc_cnt <= dbnc_n;
         step_cnt <= step_n;
         idx      <= idx_n;
         dom_en   <= dom_en_n;
         pwr_good <= pg_n;
         brownout <= bo_n;
      end
   end

   always_comb begin
      state_n  = state;
      dbnc_n   = dbnc_cnt;
      step_n   = step_cnt;
      idx_n    = idx;
      dom_en_n = dom_en;
      pg_n     = pwr_good;
      bo_n     = 1'b0;
      case (state)
         ST_OFF: begin
            dom_en_n = '0;
            pg_n     = 1'b0;
            dbnc_n   = '0;
            step_n   = '0;
            idx_n    = '0;
            if (pok_sync_o) state_n = ST_DEBOUNCE;
         end
         ST_DEBOUNCE: begin
            if (!pok_sync_o) begin
               state_n = ST_OFF;
               dbnc_n  = '0;
            end else if (dbnc_cnt == DbncLast) begin
               state_n  = ST_RAMP;
               dom_en_n = NumDomains'(1);
               step_n   = '0;
               idx_n    = '0;
               dbnc_n   = '0;
            end else begin
               dbnc_n = dbnc_cnt + DW'(1);
            end
         end
         // A pok drop outranks any ramp step scheduled on the same edge.
         ST_RAMP, ST_ON: begin
            if (!pok_sync_o) begin
               state_n  = ST_DOWN;
               pg_n     = 1'b0;
               bo_n     = 1'b1;
               step_n   = '0;
               dom_en_n = NumDomains'(therm_clr_top(8'(dom_en)));
            end else if (state == ST_RAMP) begin
               if (step_cnt == StepLast) begin
                  step_n = '0;
                  if (idx == IdxLast) begin
                     state_n = ST_ON;
                     pg_n    = 1'b1;
                  end else begin
                     dom_en_n = (dom_en << 1) | NumDomains'(1);
                     idx_n    = idx + IW'(1);
                  end
               end else begin
                  step_n = step_cnt + SW'(1);
               end
            end
         end
         ST_DOWN: begin
            pg_n = 1'b0;
            if (dom_en == '0) begin
               state_n = ST_OFF;
            end else begin
               dom_en_n = NumDomains'(therm_clr_top(8'(dom_en)));
               if (dom_en_n == '0) state_n = ST_OFF;
            end
         end
         default: begin
            state_n  = ST_OFF;
            dom_en_n = '0;
            pg_n     = 1'b0;
         end
      endcase
   end

   assign dom_en_o   = dom_en;
   assign pwr_good_o = pwr_good;
   assign brownout_o = brownout;
   assign state_o    = state;

`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
   logic glitch_evt;
   assign glitch_evt = (state == ST_DEBOUNCE && !pok_sync_o) || bo_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         glitch_cnt_o <= '0;
      end else if (glitch_clr_i) begin
         glitch_cnt_o <= '0;
      end else if (glitch_evt && glitch_cnt_o != 8'hFF) begin
         glitch_cnt_o <= glitch_cnt_o + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vcc_pok_seq.sv
// Directed bench for vcc_pok_seq: default build plus a minimal 1-domain/1-step/1-debounce instance.
module tb_vcc_pok_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pok = 1'b0;
   logic       pok2 = 1'b0;
   logic       pok_sync, pwr_good, brownout;
   logic [2:0] dom_en, state;
   logic       pok_sync2, pwr_good2, brownout2;
   logic [0:0] dom_en2;
   logic [2:0] state2;
   int         errors = 0;
   int         checks = 0;
   int         bo_cnt = 0;
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
   logic       gclr = 1'b0;
   logic [7:0] gcnt, gcnt2;
`endif

   always #5 clk = ~clk;

   vcc_pok_seq dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .vcc_pok_i  (pok),
      .pok_sync_o (pok_sync),
      .dom_en_o   (dom_en),
      .pwr_good_o (pwr_good),
      .brownout_o (brownout),
      .state_o    (state)
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
      ,
      .glitch_clr_i (gclr),
      .glitch_cnt_o (gcnt)
`endif
   );

   vcc_pok_seq #(
      .DebounceCycles (1),
      .StepCycles     (1),
      .NumDomains     (1)
   ) dut2 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .vcc_pok_i  (pok2),
      .pok_sync_o (pok_sync2),
      .dom_en_o   (dom_en2),
      .pwr_good_o (pwr_good2),
      .brownout_o (brownout2),
      .state_o    (state2)
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
      ,
      .glitch_clr_i (gclr),
      .glitch_cnt_o (gcnt2)
`endif
   );

   always @(negedge clk) if (brownout) bo_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bounded wait for pok_sync_o to reach val; returns just after the edge where it changed.
   task automatic wait_sync(input logic val, input string tag);
      int k;
      for (k = 0; k < 10; k++) begin
         @(negedge clk);
         if (pok_sync === val) break;
      end
      if (k == 10) check(tag, 32'(pok_sync), 32'(val));
   endtask

   task automatic wait_sync2(input logic val, input string tag);
      int k;
      for (k = 0; k < 10; k++) begin
         @(negedge clk);
         if (pok_sync2 === val) break;
      end
      if (k == 10) check(tag, 32'(pok_sync2), 32'(val));
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_dom_en", 32'(dom_en), 0);
      check("rst_pwr_good", 32'(pwr_good), 0);
      check("rst_brownout", 32'(brownout), 0);
      check("rst_state", 32'(state), 0);
      check("rst_pok_sync", 32'(pok_sync), 0);
      rst_n = 1'b1;
      step(2);
      check("off_idle_state", 32'(state), 0);

      // Full ramp-up; S is the edge where pok_sync rises
      pok = 1'b1;
      wait_sync(1'b1, "ramp_sync_timeout");
      step(1);
      check("ramp_debounce_S1", 32'(state), 1);
      step(15);
      check("ramp_dom_S16", 32'(dom_en), 0);
      check("ramp_state_S16", 32'(state), 1);
      step(1);
      check("ramp_dom_S17", 32'(dom_en), 3'b001);
      check("ramp_state_S17", 32'(state), 2);
      step(7);
      check("ramp_dom_S24", 32'(dom_en), 3'b001);
      step(1);
      check("ramp_dom_S25", 32'(dom_en), 3'b011);
      step(8);
      check("ramp_dom_S33", 32'(dom_en), 3'b111);
      step(7);
      check("ramp_pg_S40", 32'(pwr_good), 0);
      step(1);
      check("ramp_pg_S41", 32'(pwr_good), 1);
      check("ramp_state_S41", 32'(state), 3);
      check("ramp_no_brownout", 32'(bo_cnt), 0);

      // Loss in ON: reverse teardown
      pok = 1'b0;
      wait_sync(1'b0, "on_drop_sync_timeout");
      check("on_drop_pre_state", 32'(state), 3);
      step(1);
      check("drop_D_pg", 32'(pwr_good), 0);
      check("drop_D_bo", 32'(brownout), 1);
      check("drop_D_dom", 32'(dom_en), 3'b011);
      check("drop_D_state", 32'(state), 4);
      step(1);
      check("drop_D1_dom", 32'(dom_en), 3'b001);
      check("drop_D1_bo", 32'(brownout), 0);
      step(1);
      check("drop_D2_dom", 32'(dom_en), 0);
      check("drop_D2_state", 32'(state), 0);
      check("drop_bo_count", 32'(bo_cnt), 1);
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
      check("glitch_after_drop", 32'(gcnt), 1);
`endif

      // Short pok pulse aborts debounce
      step(2);
      pok = 1'b1;
      wait_sync(1'b1, "glitch_sync_timeout");
      step(9);
      pok = 1'b0;
      step(2);
      check("glitch_sync_low", 32'(pok_sync), 0);
      check("glitch_still_dbnc", 32'(state), 1);
      step(1);
      check("glitch_off", 32'(state), 0);
      check("glitch_dom", 32'(dom_en), 0);
      check("glitch_no_bo", 32'(bo_cnt), 1);
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
      check("glitch_cnt", 32'(gcnt), 2);
`endif

      // Drop during RAMP at 011, pok restored during DOWN
      step(2);
      pok = 1'b1;
      wait_sync(1'b1, "rampdrop_sync_timeout");
      step(25);
      check("rampdrop_S25_dom", 32'(dom_en), 3'b011);
      pok = 1'b0;
      step(2);
      check("rampdrop_S27_dom", 32'(dom_en), 3'b011);
      check("rampdrop_S27_state", 32'(state), 2);
      pok = 1'b1;
      step(1);
      check("rampdrop_S28_state", 32'(state), 4);
      check("rampdrop_S28_dom", 32'(dom_en), 3'b001);
      check("rampdrop_S28_bo", 32'(brownout), 1);
      step(1);
      check("rampdrop_S29_dom", 32'(dom_en), 0);
      check("rampdrop_S29_state", 32'(state), 0);
      step(1);
      check("rampdrop_S30_state", 32'(state), 1);
      step(15);
      check("rampdrop_S45_dom", 32'(dom_en), 0);
      step(1);
      check("rampdrop_S46_dom", 32'(dom_en), 3'b001);
      step(24);
      check("rampdrop_on_pg", 32'(pwr_good), 1);
      check("rampdrop_on_state", 32'(state), 3);

      // Async reset in ON, observed before the next clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dom", 32'(dom_en), 0);
      check("arst_pg", 32'(pwr_good), 0);
      check("arst_state", 32'(state), 0);
      check("arst_sync", 32'(pok_sync), 0);
`ifdef VCC_POK_SEQ_GLITCH_CNT_EN
      check("arst_gcnt", 32'(gcnt), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      wait_sync(1'b1, "arst_sync_timeout");
      step(1);
      check("arst_restart_dbnc", 32'(state), 1);
      step(16);
      check("arst_restart_dom", 32'(dom_en), 3'b001);
      step(24);
      check("arst_restart_pg", 32'(pwr_good), 1);

      // Minimal configuration instance
      pok2 = 1'b1;
      wait_sync2(1'b1, "min_sync_timeout");
      step(1);
      check("min_dbnc_state", 32'(state2), 1);
      step(1);
      check("min_dom_en", 32'(dom_en2), 1);
      check("min_pg_early", 32'(pwr_good2), 0);
      step(1);
      check("min_pg", 32'(pwr_good2), 1);
      check("min_on_state", 32'(state2), 3);
      pok2 = 1'b0;
      wait_sync2(1'b0, "min_drop_sync_timeout");
      step(1);
      check("min_drop_bo", 32'(brownout2), 1);
      check("min_drop_dom", 32'(dom_en2), 0);
      check("min_drop_state", 32'(state2), 4);
      step(1);
      check("min_off_state", 32'(state2), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
